// File: rtl/ffdiv_pkg.sv
// Shared definitions for the binary32 divider front end and datapath.
package ffdiv_pkg;

  localparam int unsigned OPERAND_WIDTH     = 32;
  localparam int unsigned SIGNIFICAND_WIDTH = 24;
  localparam int unsigned FRAC_WIDTH        = 23;
  localparam int unsigned EXP_WIDTH         = 8;
  localparam int unsigned UNB_EXP_WIDTH     = 10;
  localparam int unsigned EXP_BIAS          = 127;

  localparam logic signed [UNB_EXP_WIDTH-1:0] NORM_EXP_MIN   = -10'sd126;
  localparam logic signed [UNB_EXP_WIDTH-1:0] DENORM_EXP_MIN = -10'sd149;

  localparam logic [OPERAND_WIDTH-1:0] QNAN_MASK = 32'h0040_0000;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_DENORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_NORMALIZE,
    ST_HOLD
  } dec_state_e;

  // Operand class from the raw exponent and fraction fields.
  function automatic op_class_e classify(input logic [EXP_WIDTH-1:0]  exp_f,
                                         input logic [FRAC_WIDTH-1:0] frac_f);
    op_class_e c;
    if (exp_f == '1)      c = (frac_f != '0) ? CLS_NAN : CLS_INF;
    else if (exp_f == '0) c = (frac_f != '0) ? CLS_DENORM : CLS_ZERO;
    else                  c = CLS_NORM;
    return c;
  endfunction

endpackage

// File: rtl/ffdiv_operand_unpack.sv
// One operand: raw capture, field classification and bit-serial normalization.
module ffdiv_operand_unpack
  import ffdiv_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture,
  input  logic                          load,
  input  logic                          shift,
  input  logic [OPERAND_WIDTH-1:0]      raw_in,
  output logic [OPERAND_WIDTH-1:0]      raw,
  output op_class_e                     cls_c,
  output logic                          done_next_c,
  output logic                          sign,
  output logic [UNB_EXP_WIDTH-1:0]      unb_exp,
  output logic [SIGNIFICAND_WIDTH-1:0]  sgfnd,
  output logic                          is_norm,
  output logic                          is_denorm
);

  logic [EXP_WIDTH-1:0]         exp_f;
  logic [FRAC_WIDTH-1:0]        frac_f;
  logic [SIGNIFICAND_WIDTH-1:0] sgfnd_load_c;
  logic [UNB_EXP_WIDTH-1:0]     exp_load_c;
  logic                         done_c;

  assign exp_f  = raw[30:23];
  assign frac_f = raw[22:0];
  assign cls_c  = classify(exp_f, frac_f);

  // Only denormals ever need shifting; everything else is done on load.
  assign done_c      = sgfnd[SIGNIFICAND_WIDTH-1] | ~is_denorm;
  assign done_next_c = done_c | sgfnd[SIGNIFICAND_WIDTH-2];

  // Decoded fields to be loaded from the captured operand.
  always_comb begin
    sgfnd_load_c = {1'b0, frac_f};
    exp_load_c   = '0;
    case (cls_c)
      CLS_NORM: begin
        sgfnd_load_c = {1'b1, frac_f};
        exp_load_c   = UNB_EXP_WIDTH'(exp_f) - UNB_EXP_WIDTH'(EXP_BIAS);
      end
      CLS_DENORM: exp_load_c = NORM_EXP_MIN;
      default: ;
    endcase
  end

  // Raw operand register, written on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          raw <= '0;
    else if (capture) raw <= raw_in;
  end

  // Decoded field registers: load after classify, shift while normalizing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign      <= 1'b0;
      unb_exp   <= '0;
      sgfnd     <= '0;
      is_norm   <= 1'b0;
      is_denorm <= 1'b0;
    end else if (load) begin
      sign      <= raw[OPERAND_WIDTH-1];
      unb_exp   <= exp_load_c;
      sgfnd     <= sgfnd_load_c;
      is_norm   <= (cls_c == CLS_NORM);
      is_denorm <= (cls_c == CLS_DENORM);
    end else if (shift && !done_c) begin
      sgfnd   <= {sgfnd[SIGNIFICAND_WIDTH-2:0], 1'b0};
      unb_exp <= unb_exp - UNB_EXP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ffdiv_operand_decoder.sv
// Divider front end: operand FSM, special-result resolution and HOLD handshake.
module ffdiv_operand_decoder
  import ffdiv_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          start,
  input  logic [OPERAND_WIDTH-1:0]      a,
  input  logic [OPERAND_WIDTH-1:0]      b,
  input  logic                          div_ready,
  output logic                          busy,
  output logic                          dec_valid,
  output logic                          sign1,
  output logic                          sign2,
  output logic [UNB_EXP_WIDTH-1:0]      unb_exp1,
  output logic [UNB_EXP_WIDTH-1:0]      unb_exp2,
  output logic [SIGNIFICAND_WIDTH-1:0]  sgfnd1,
  output logic [SIGNIFICAND_WIDTH-1:0]  sgfnd2,
  output logic                          is_norm1,
  output logic                          is_norm2,
  output logic                          is_denorm1,
  output logic                          is_denorm2,
  output logic [OPERAND_WIDTH-1:0]      res_nan,
  output logic                          res_indet,
  output logic                          res_inf,
  output logic                          res_zero
);

  dec_state_e state, state_next;
  logic capture_c, load_c, shift_c;

  logic [OPERAND_WIDTH-1:0] raw1, raw2;
  op_class_e cls1_c, cls2_c;
  logic done_next1_c, done_next2_c;

  logic nan1_c, nan2_c, inf1_c, inf2_c, zero1_c, zero2_c, fnz1_c, fnz2_c;
  logic [OPERAND_WIDTH-1:0] res_nan_c;
  logic res_indet_c, res_inf_c, res_zero_c;

  ffdiv_operand_unpack u_op1 (
    .clk(clk), .rst(rst), .capture(capture_c), .load(load_c), .shift(shift_c),
    .raw_in(a), .raw(raw1), .cls_c(cls1_c), .done_next_c(done_next1_c),
    .sign(sign1), .unb_exp(unb_exp1), .sgfnd(sgfnd1),
    .is_norm(is_norm1), .is_denorm(is_denorm1)
  );

  ffdiv_operand_unpack u_op2 (
    .clk(clk), .rst(rst), .capture(capture_c), .load(load_c), .shift(shift_c),
    .raw_in(b), .raw(raw2), .cls_c(cls2_c), .done_next_c(done_next2_c),
    .sign(sign2), .unb_exp(unb_exp2), .sgfnd(sgfnd2),
    .is_norm(is_norm2), .is_denorm(is_denorm2)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and datapath strobes; nothing moves while en is low.
  always_comb begin
    state_next = state;
    capture_c  = 1'b0;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            capture_c  = 1'b1;
            state_next = ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          load_c     = 1'b1;
          state_next = (cls1_c == CLS_DENORM || cls2_c == CLS_DENORM) ?
                       ST_NORMALIZE : ST_HOLD;
        end
        ST_NORMALIZE: begin
          shift_c = 1'b1;
          if (done_next1_c && done_next2_c) state_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (div_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign nan1_c  = (cls1_c == CLS_NAN);
  assign nan2_c  = (cls2_c == CLS_NAN);
  assign inf1_c  = (cls1_c == CLS_INF);
  assign inf2_c  = (cls2_c == CLS_INF);
  assign zero1_c = (cls1_c == CLS_ZERO);
  assign zero2_c = (cls2_c == CLS_ZERO);
  assign fnz1_c  = (cls1_c == CLS_NORM) || (cls1_c == CLS_DENORM);
  assign fnz2_c  = (cls2_c == CLS_NORM) || (cls2_c == CLS_DENORM);

  // Special-result resolution: NaN, then indeterminate, infinity, zero.
  always_comb begin
    res_nan_c   = '0;
    res_indet_c = 1'b0;
    res_inf_c   = 1'b0;
    res_zero_c  = 1'b0;
    if (nan1_c)                                         res_nan_c   = raw1 | QNAN_MASK;
    else if (nan2_c)                                    res_nan_c   = raw2 | QNAN_MASK;
    else if ((zero1_c && zero2_c) || (inf1_c && inf2_c)) res_indet_c = 1'b1;
    else if (inf1_c || (fnz1_c && zero2_c))             res_inf_c   = 1'b1;
    else if (zero1_c || inf2_c)                         res_zero_c  = 1'b1;
  end

  // Registered special results, captured once per operand pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_nan   <= '0;
      res_indet <= 1'b0;
      res_inf   <= 1'b0;
      res_zero  <= 1'b0;
    end else if (load_c) begin
      res_nan   <= res_nan_c;
      res_indet <= res_indet_c;
      res_inf   <= res_inf_c;
      res_zero  <= res_zero_c;
    end
  end

  // Handshake outputs: busy tracks the state, dec_valid follows HOLD a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      dec_valid <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (en) dec_valid <= (state == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_ffdiv_operand_decoder.sv
// Randomized and directed checks of the operand decoder against an arithmetic model.
module tb_ffdiv_operand_decoder;
  import ffdiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, start, div_ready;
  logic [31:0] a, b;
  logic        busy, dec_valid, sign1, sign2;
  logic [9:0]  unb_exp1, unb_exp2;
  logic [23:0] sgfnd1, sgfnd2;
  logic        is_norm1, is_norm2, is_denorm1, is_denorm2;
  logic [31:0] res_nan;
  logic        res_indet, res_inf, res_zero;

  int n_cmp = 0;
  int n_err = 0;

  ffdiv_operand_decoder dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b),
    .div_ready(div_ready), .busy(busy), .dec_valid(dec_valid),
    .sign1(sign1), .sign2(sign2), .unb_exp1(unb_exp1), .unb_exp2(unb_exp2),
    .sgfnd1(sgfnd1), .sgfnd2(sgfnd2), .is_norm1(is_norm1), .is_norm2(is_norm2),
    .is_denorm1(is_denorm1), .is_denorm2(is_denorm2), .res_nan(res_nan),
    .res_indet(res_indet), .res_inf(res_inf), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [23:0] g;
    logic        n;
    logic        d;
    int          lz;
    int          c;   // 0 normal, 1 denormal, 2 zero, 3 inf, 4 NaN
  } opm_t;

  // Reference decode of one operand using integer arithmetic.
  function automatic opm_t mdl(input logic [31:0] x);
    opm_t m;
    int eb, fr, ex;
    eb = int'(x[30:23]);
    fr = int'(x[22:0]);
    ex = 0;
    m.s = x[31]; m.lz = 0; m.n = 1'b0; m.d = 1'b0;
    if (eb == 255) m.c = (fr != 0) ? 4 : 3;
    else if (eb == 0 && fr == 0) m.c = 2;
    else if (eb == 0) begin
      m.c = 1; m.d = 1'b1; ex = -126;
      while (fr < 8388608) begin
        fr = fr * 2; ex = ex - 1; m.lz = m.lz + 1;
      end
    end else begin
      m.c = 0; m.n = 1'b1; ex = eb - 127; fr = fr + 8388608;
    end
    m.e = 10'(ex);
    m.g = 24'(fr);
    return m;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    logic [22:0] f;
    int k;
    k = int'($urandom_range(0, 5));
    r = $urandom;
    f = 23'($urandom);
    case (k)
      0: r[30:23] = 8'($urandom_range(1, 254));
      1: begin
        f = f >> $urandom_range(0, 22);
        if (f == '0) f = 23'd1;
        r[30:23] = 8'h00; r[22:0] = f;
      end
      2: r[30:0] = '0;
      3: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      4: begin r[30:23] = 8'hFF; if (r[22:0] == '0) r[0] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start an operand pair and count edges until dec_valid; optional en-low gap.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input int gap,
                        output int cyc);
    @(negedge clk); a = ta; b = tb_; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!dec_valid && cyc < 60) begin
      if (gap > 0 && cyc == 5) en = 1'b0;
      if (gap > 0 && cyc == 5 + gap) en = 1'b1;
      @(posedge clk); cyc++; #1;
    end
    en = 1'b1;
  endtask

  task automatic check_op(input logic [31:0] ta, input logic [31:0] tb_, input int gap,
                          input int cyc);
    opm_t ma, mb;
    logic [31:0] rn;
    logic ri, rf, rz;
    int lz;
    ma = mdl(ta);
    mb = mdl(tb_);
    lz = (ma.lz > mb.lz) ? ma.lz : mb.lz;
    rn = '0; ri = 1'b0; rf = 1'b0; rz = 1'b0;
    if (ma.c == 4) rn = ta | 32'h0040_0000;
    else if (mb.c == 4) rn = tb_ | 32'h0040_0000;
    else if ((ma.c == 2 && mb.c == 2) || (ma.c == 3 && mb.c == 3)) ri = 1'b1;
    else if ((ma.c == 3) || (ma.c <= 1 && mb.c == 2)) rf = 1'b1;
    else if ((ma.c == 2 && mb.c <= 1) || (mb.c == 3)) rz = 1'b1;
    chk("latency", 32'(cyc), 32'(2 + lz + gap));
    chk("dec_valid", 32'(dec_valid), 32'd1);
    chk("busy_hold", 32'(busy), 32'd1);
    chk("sign1", 32'(sign1), 32'(ma.s));
    chk("sign2", 32'(sign2), 32'(mb.s));
    chk("unb_exp1", 32'(unb_exp1), 32'(ma.e));
    chk("unb_exp2", 32'(unb_exp2), 32'(mb.e));
    chk("sgfnd1", 32'(sgfnd1), 32'(ma.g));
    chk("sgfnd2", 32'(sgfnd2), 32'(mb.g));
    chk("class1", {30'd0, is_norm1, is_denorm1}, {30'd0, ma.n, ma.d});
    chk("class2", {30'd0, is_norm2, is_denorm2}, {30'd0, mb.n, mb.d});
    chk("res_nan", res_nan, rn);
    chk("res_flags", {29'd0, res_indet, res_inf, res_zero}, {29'd0, ri, rf, rz});
  endtask

  task automatic release_op();
    @(negedge clk); div_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_release", 32'(busy), 32'd0);
    @(negedge clk); div_ready = 1'b0;
    @(posedge clk); #1;
    chk("dec_valid_release", 32'(dec_valid), 32'd0);
  endtask

  task automatic run(input logic [31:0] ta, input logic [31:0] tb_);
    int cyc;
    launch(ta, tb_, 0, cyc);
    check_op(ta, tb_, 0, cyc);
    release_op();
  endtask

  initial begin
    int cyc;
    rst = 1'b1; en = 1'b1; start = 1'b0; div_ready = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sgfnd1", 32'(sgfnd1), 32'd0);
    chk("rst_res_nan", res_nan, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Directed operand pairs
    run(32'h40C0_0000, 32'h4000_0000);
    run(32'h0000_0001, 32'h3F80_0000);
    run(32'h7F80_0001, 32'h7FC0_0002);
    run(32'h0000_0000, 32'h8000_0000);
    run(32'h3F80_0000, 32'h0000_0000);
    run(32'h0000_0000, 32'h7F80_0000);
    run(32'hFF80_0000, 32'h7F80_0000);
    run(32'h0040_0000, 32'h8000_0003);

    // HOLD persists without div_ready and ignores start
    launch(32'h40C0_0000, 32'h4000_0000, 0, cyc);
    check_op(32'h40C0_0000, 32'h4000_0000, 0, cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      a = 32'h0000_0005; b = 32'h7F80_0000;
      @(posedge clk); #1;
      chk("hold_dec_valid", 32'(dec_valid), 32'd1);
      chk("hold_sgfnd1", 32'(sgfnd1), 32'h00C0_0000);
      chk("hold_unb_exp1", 32'(unb_exp1), 32'd2);
      chk("hold_res_zero", 32'(res_zero), 32'd0);
    end
    @(negedge clk); start = 1'b0;
    release_op();

    // Asynchronous reset during NORMALIZE
    @(negedge clk); a = 32'h0000_0010; b = 32'h3F80_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sgfnd1", 32'(sgfnd1), 32'd0);
    chk("mid_rst_unb_exp1", 32'(unb_exp1), 32'd0);
    chk("mid_rst_denorm1", 32'(is_denorm1), 32'd0);
    chk("mid_rst_norm2", 32'(is_norm2), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", {30'd0, busy, dec_valid}, 32'd0);

    // en low for 5 cycles during NORMALIZE
    launch(32'h0000_0010, 32'h3F80_0000, 5, cyc);
    check_op(32'h0000_0010, 32'h3F80_0000, 5, cyc);
    release_op();

    // Randomized operand pairs
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = rnd_op();
      rb = rnd_op();
      run(ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
